// File: rtl/result_source_pkg.sv
// rtl/result_source_pkg.sv - shared result-source encoding, types and helpers
package result_source_pkg;

    localparam int RS_W   = 2;
    localparam int RS_NUM = 1 << RS_W;

    typedef enum logic [RS_W-1:0] {
        RS_ALU  = 2'b00,
        RS_MEM  = 2'b01,
        RS_PC4  = 2'b10,
        RS_VMEM = 2'b11
    } result_source_e;

    // One-hot view of a select; bit n set when the select equals n
    function automatic logic [RS_NUM-1:0] to_onehot(input result_source_e rs);
        logic [RS_NUM-1:0] oh;
        oh = '0;
        oh[rs] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/result_source_decoder_rv32i_if.sv
// rtl/result_source_decoder_rv32i_if.sv - control-flag inputs and registered result-select outputs
interface result_source_decoder_rv32i_if;
    import result_source_pkg::*;

    logic                 en;
    logic                 flush;
    logic                 load;
    logic                 jump;
    logic                 i_jump;
    logic                 load_vector;
    logic                 f3_eq_0;
    logic [RS_W-1:0]      result_source;
    logic [RS_NUM-1:0]    result_onehot;
    logic                 illegal;

    // Decode stage side: drives control flags, observes the registered select
    modport master (
        output en, flush, load, jump, i_jump, load_vector, f3_eq_0,
        input  result_source, result_onehot, illegal
    );

    // Decoder side: consumes control flags, produces the registered select
    modport slave (
        input  en, flush, load, jump, i_jump, load_vector, f3_eq_0,
        output result_source, result_onehot, illegal
    );
endinterface

// File: rtl/result_source_decode_comb.sv
// rtl/result_source_decode_comb.sv - combinational priority decode of result source and illegal detect
module result_source_decode_comb
    import result_source_pkg::*;
(
    input  logic           load,
    input  logic           jump,
    input  logic           i_jump,
    input  logic           load_vector,
    input  logic           f3_eq_0,
    output result_source_e rs_next,
    output logic           illegal_next
);

    logic       jalr_ok;
    logic       jalr_bad;
    logic       jmp;
    logic [1:0] req_cnt;

    // JALR is only a jump when funct3 is zero; otherwise it is a malformed encoding
    always_comb begin
        jalr_ok  = i_jump & f3_eq_0;
        jalr_bad = i_jump & ~f3_eq_0;
        jmp      = jump | jalr_ok;
        req_cnt  = {1'b0, jmp} + {1'b0, load_vector} + {1'b0, load};
    end

    // Link value beats vector load beats scalar load; ALU is the fallback
    always_comb begin
        rs_next = RS_ALU;
        if (jmp) begin
            rs_next = RS_PC4;
        end else if (load_vector) begin
            rs_next = RS_VMEM;
        end else if (load) begin
            rs_next = RS_MEM;
        end
    end

    // Flag bad JALR funct3 or conflicting source requests from the main decoder
    always_comb begin
        illegal_next = jalr_bad | (req_cnt > 2'd1);
    end

endmodule

// File: rtl/result_source_decoder_rv32i.sv
// rtl/result_source_decoder_rv32i.sv - registered writeback result-source select with stall and flush
module result_source_decoder_rv32i
    import result_source_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    result_source_decoder_rv32i_if.slave  bus
);

    result_source_e    rs_next;
    logic              illegal_next;
    result_source_e    rs_q;
    logic [RS_NUM-1:0] onehot_q;
    logic              illegal_q;

    result_source_decode_comb u_decode (
        .load         (bus.load),
        .jump         (bus.jump),
        .i_jump       (bus.i_jump),
        .load_vector  (bus.load_vector),
        .f3_eq_0      (bus.f3_eq_0),
        .rs_next      (rs_next),
        .illegal_next (illegal_next)
    );

    // Pipeline register: reset and flush both insert an ALU bubble, en=0 holds
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            rs_q      <= RS_ALU;
            onehot_q  <= to_onehot(RS_ALU);
            illegal_q <= 1'b0;
        end else if (bus.en) begin
            rs_q      <= rs_next;
            onehot_q  <= to_onehot(rs_next);
            illegal_q <= illegal_next;
        end
    end

    // One-hot is captured from the same next-state select so the two never diverge
    always_comb begin
        bus.result_source = rs_q;
        bus.result_onehot = onehot_q;
        bus.illegal       = illegal_q;
    end

endmodule

// File: tb/tb_result_source_decoder_rv32i.sv
// tb/tb_result_source_decoder_rv32i.sv - scoreboard bench for the result-source decoder
module tb_result_source_decoder_rv32i;

    typedef struct {
        logic [1:0] rs;
        logic [3:0] oh;
        logic       ill;
        string      name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    result_source_decoder_rv32i_if bus_if ();

    result_source_decoder_rv32i dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input string field, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%b required=%b", name, field, act, req);
        end
    endtask

    // Monitor: each edge the register presents a new output; pop and compare
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check1(e.name, "result_source", {2'b00, bus_if.result_source}, {2'b00, e.rs});
            check1(e.name, "result_onehot", bus_if.result_onehot, e.oh);
            check1(e.name, "illegal", {3'b000, bus_if.illegal}, {3'b000, e.ill});
        end
    end

    // Drive one vector away from the edge and push the hand-computed result
    task automatic step(input logic rn, input logic en, input logic fl,
                        input logic ld, input logic jp, input logic ij,
                        input logic lv, input logic f3,
                        input logic [1:0] rs, input logic [3:0] oh, input logic ill,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst_n              = rn;
        bus_if.en          = en;
        bus_if.flush       = fl;
        bus_if.load        = ld;
        bus_if.jump        = jp;
        bus_if.i_jump      = ij;
        bus_if.load_vector = lv;
        bus_if.f3_eq_0     = f3;
        e.rs   = rs;
        e.oh   = oh;
        e.ill  = ill;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n              = 1'b0;
        bus_if.en          = 1'b1;
        bus_if.flush       = 1'b0;
        bus_if.load        = 1'b1;
        bus_if.jump        = 1'b0;
        bus_if.i_jump      = 1'b0;
        bus_if.load_vector = 1'b0;
        bus_if.f3_eq_0     = 1'b0;

        //   rn en fl ld jp ij lv f3   rs     onehot   ill
        step(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0001, 0, "reset_0");
        step(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0001, 0, "reset_1");
        step(1, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'b0010, 0, "load");
        step(1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 4'b0100, 0, "jal");
        step(1, 1, 0, 0, 0, 1, 0, 1, 2'b10, 4'b0100, 0, "jalr_ok");
        step(1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0001, 1, "jalr_bad");
        step(1, 1, 0, 0, 0, 0, 1, 0, 2'b11, 4'b1000, 0, "vload");
        step(1, 1, 0, 1, 0, 0, 1, 0, 2'b11, 4'b1000, 1, "load_vload");
        step(1, 1, 0, 1, 1, 0, 0, 0, 2'b10, 4'b0100, 1, "jal_load");
        step(1, 0, 0, 1, 0, 0, 0, 0, 2'b10, 4'b0100, 1, "hold_illegal");
        step(1, 1, 0, 1, 0, 1, 0, 1, 2'b10, 4'b0100, 1, "jalr_load");
        step(1, 1, 0, 0, 0, 0, 1, 1, 2'b11, 4'b1000, 0, "f3_no_ijump");
        step(1, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'b0010, 0, "stall_pre");
        step(1, 0, 0, 0, 1, 0, 0, 0, 2'b01, 4'b0010, 0, "stall_0");
        step(1, 0, 0, 0, 1, 0, 0, 0, 2'b01, 4'b0010, 0, "stall_1");
        step(1, 0, 0, 0, 1, 0, 0, 0, 2'b01, 4'b0010, 0, "stall_2");
        step(1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 4'b0100, 0, "stall_release");
        step(1, 1, 0, 1, 1, 0, 0, 0, 2'b10, 4'b0100, 1, "pre_flush");
        step(1, 0, 1, 0, 1, 0, 0, 0, 2'b00, 4'b0001, 0, "flush_over_stall");
        step(1, 1, 0, 0, 0, 0, 1, 0, 2'b11, 4'b1000, 0, "pre_reset");
        step(0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 4'b0001, 0, "reset_flush");
        step(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, "all_zero");
        step(1, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'b0010, 0, "load_again");
        step(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0001, 0, "reset_over_stall");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
